// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests, loads IF/ID and redirects on taken BEQ / J, discarding stale words.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_id,
  input  logic        cmp_equal,
  input  logic [31:0] branch_target,
  input  logic        jump_id,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        flush
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        w_ifid_valid_next;
  logic        w_load;
  logic        w_accept;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Stall outranks redirect: branch operands may not be forwarded yet.
  assign w_redirect = r_ifid_valid & ~stall & (jump_id | (branch_id & cmp_equal));
  assign w_accept   = imem_valid & imem_ready;
  assign w_target   = jump_id ? jump_target : branch_target;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign flush      = w_redirect;
  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
  assign imem_req   = (r_state == S_ISSUE);
  assign imem_ready = (r_state == S_WAIT) ? ~stall : (r_state == S_DISCARD);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE:  w_state_next = S_ISSUE;
      S_ISSUE: begin
        // The request to the old PC is already out, so its word must be eaten.
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = S_DISCARD;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = w_accept ? S_ISSUE : S_DISCARD;
        end else if (w_accept) begin
          w_load       = 1'b1;
          w_pc_next    = w_pc_plus4;
          w_state_next = S_ISSUE;
        end
      end
      S_DISCARD: begin
        if (imem_valid) w_state_next = S_ISSUE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // A redirect implies ~stall, so it always lands on the bubble branch.
    if (w_load)     w_ifid_valid_next = 1'b1;
    else if (stall) w_ifid_valid_next = r_ifid_valid;
    else            w_ifid_valid_next = 1'b0;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_valid <= w_ifid_valid_next;
      if (w_load) begin
        r_ifid_instr <= imem_rdata;
        r_ifid_pc4   <= w_pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: variable-latency memory model plus
// request / IF-IF scoreboards fed by the scenario tasks.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_id;
  logic        cmp_equal;
  logic [31:0] branch_target;
  logic        jump_id;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        flush;

  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 1;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_ifid_q[$];

  mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_id(branch_id),
    .cmp_equal(cmp_equal), .branch_target(branch_target), .jump_id(jump_id),
    .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_5A00;
  endfunction

  // Memory model: requests and accepts are sampled 2 units after the falling
  // edge (inputs are stable by then) and applied 1 unit after the rising edge.
  initial begin : mem_model
    logic        busy, rec_req, rec_acc;
    logic [31:0] mem_addr, rec_addr;
    int          cnt, rec_lat;
    busy = 0; rec_req = 0; rec_acc = 0; cnt = 0; rec_lat = 1;
    mem_addr = '0; rec_addr = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        imem_valid = 1'b0; busy = 0; rec_req = 0; rec_acc = 0;
      end else begin
        if (rec_acc) imem_valid = 1'b0;
        if (rec_req) begin busy = 1; mem_addr = rec_addr; cnt = rec_lat; end
        if (busy && !imem_valid) begin
          cnt--;
          if (cnt <= 0) begin
            imem_valid = 1'b1; imem_rdata = mem_word(mem_addr); busy = 0;
          end
        end
      end
      @(negedge clk); #2;
      rec_req  = rst_n && imem_req;
      rec_addr = imem_addr;
      rec_lat  = mem_lat;
      rec_acc  = rst_n && imem_valid && imem_ready;
    end
  end

  // Scoreboard monitor: pops one expected address per request and one expected
  // PC+4 per newly loaded IF/ID entry.
  initial begin : monitor
    logic        prev_v;
    logic [31:0] prev_pc4, e;
    prev_v = 0; prev_pc4 = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n === 1'b1) begin
        if (imem_req) begin
          n_total++;
          if (exp_req_q.size() == 0) $display("FAIL req_unexpected: got addr %h, none expected", imem_addr);
          else begin
            e = exp_req_q.pop_front();
            if (imem_addr !== e) $display("FAIL req_addr: got %h exp %h", imem_addr, e);
            else n_pass++;
          end
        end
        if (ifid_valid && (!prev_v || ifid_pc4 != prev_pc4)) begin
          n_total++;
          if (exp_ifid_q.size() == 0) $display("FAIL ifid_unexpected: got pc4 %h, none expected", ifid_pc4);
          else begin
            e = exp_ifid_q.pop_front();
            if (ifid_pc4 !== e || ifid_instr !== mem_word(e - 32'd4))
              $display("FAIL ifid_load: got pc4 %h instr %h exp pc4 %h instr %h",
                       ifid_pc4, ifid_instr, e, mem_word(e - 32'd4));
            else n_pass++;
          end
        end
      end
      prev_v = ifid_valid; prev_pc4 = ifid_pc4;
    end
  end

  // Step to the ISSUE cycle whose IF/ID holds the given PC+4.
  task automatic wait_issue(input logic [31:0] pc4_exp);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_req && ifid_valid && ifid_pc4 == pc4_exp) begin found = 1; break; end
    end
    if (!found) begin
      n_total++;
      $display("FAIL wait_issue_timeout: got pc4 %h exp %h", ifid_pc4, pc4_exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 0; branch_id = 0; cmp_equal = 0; jump_id = 0;
    branch_target = '0; jump_target = '0; mem_lat = 1;
    repeat (3) @(negedge clk);
    n_total++; if (pc !== 32'h0)      $display("FAIL rst_pc: got %h exp %h", pc, 32'h0); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else n_pass++;
    n_total++; if (imem_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", imem_ready); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL rst_ifid_valid: got %b exp 0", ifid_valid); else n_pass++;
    n_total++; if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0)
      $display("FAIL rst_ifid: got instr %h pc4 %h exp 0 0", ifid_instr, ifid_pc4); else n_pass++;
  endtask

  task automatic test_seq_fetch;
    bit seen = 0, found = 0;
    foreach (exp_req_q[i]) ;
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8); exp_req_q.push_back(32'hC);
    exp_ifid_q.push_back(32'h4); exp_ifid_q.push_back(32'h8); exp_ifid_q.push_back(32'hC);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifid_valid) seen = 1;
      if (seen) begin
        n_total++;
        if (ifid_valid !== imem_req) $display("FAIL seq_toggle: got valid %b exp %b", ifid_valid, imem_req);
        else n_pass++;
      end
      if (imem_req && ifid_valid && ifid_pc4 == 32'hC) begin found = 1; break; end
    end
    if (!found) begin n_total++; $display("FAIL seq_timeout: got pc4 %h exp %h", ifid_pc4, 32'hC); end
  endtask

  task automatic test_branch_same_cycle;
    stall = 1;                      // hold IF/ID into WAIT so the BEQ sits in ID
    @(negedge clk);
    stall = 0; branch_id = 1; cmp_equal = 1; branch_target = 32'h40;
    exp_req_q.push_back(32'h40);
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL beq_flush: got %b exp 1", flush); else n_pass++;
    n_total++; if (imem_ready !== 1'b1) $display("FAIL beq_ready: got %b exp 1", imem_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (pc !== 32'h40) $display("FAIL beq_pc: got %h exp %h", pc, 32'h40); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL beq_ifid_valid: got %b exp 0", ifid_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL beq_next_req: got %b exp 1", imem_req); else n_pass++;
    branch_id = 0; cmp_equal = 0;
  endtask

  task automatic test_stall_branch;
    exp_req_q.push_back(32'h44); exp_ifid_q.push_back(32'h44);
    wait_issue(32'h44);
    stall = 1;
    @(negedge clk);
    branch_id = 1; cmp_equal = 1; branch_target = 32'h80;
    #1;
    n_total++; if (flush !== 1'b0) $display("FAIL stall_flush: got %b exp 0", flush); else n_pass++;
    n_total++; if (imem_ready !== 1'b0) $display("FAIL stall_ready: got %b exp 0", imem_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (pc !== 32'h44) $display("FAIL stall_pc: got %h exp %h", pc, 32'h44); else n_pass++;
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44)
      $display("FAIL stall_ifid: got valid %b pc4 %h exp 1 %h", ifid_valid, ifid_pc4, 32'h44); else n_pass++;
    stall = 0;
    exp_req_q.push_back(32'h80);
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL unstall_flush: got %b exp 1", flush); else n_pass++;
    @(negedge clk);
    n_total++; if (pc !== 32'h80 || ifid_valid !== 1'b0)
      $display("FAIL unstall_redirect: got pc %h valid %b exp %h 0", pc, ifid_valid, 32'h80); else n_pass++;
    branch_id = 0; cmp_equal = 0;
  endtask

  task automatic test_not_taken;
    exp_req_q.push_back(32'h84); exp_ifid_q.push_back(32'h84);
    wait_issue(32'h84);
    stall = 1;
    @(negedge clk);
    stall = 0; branch_id = 1; cmp_equal = 0; branch_target = 32'h200;
    exp_ifid_q.push_back(32'h88); exp_req_q.push_back(32'h88);
    #1;
    n_total++; if (flush !== 1'b0) $display("FAIL nt_flush: got %b exp 0", flush); else n_pass++;
    @(negedge clk);
    n_total++; if (pc !== 32'h88) $display("FAIL nt_pc: got %h exp %h", pc, 32'h88); else n_pass++;
    n_total++; if (ifid_valid !== 1'b1) $display("FAIL nt_ifid_valid: got %b exp 1", ifid_valid); else n_pass++;
    branch_id = 0;
  endtask

  task automatic test_redirect_outstanding;
    int n = 0;
    bit found = 0;
    mem_lat = 4;                    // response to 0x88 arrives 4 cycles after ISSUE
    stall = 1;
    @(negedge clk);
    stall = 0; jump_id = 1; jump_target = 32'h100;
    exp_req_q.push_back(32'h100);
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL j_flush: got %b exp 1", flush); else n_pass++;
    @(negedge clk);
    jump_id = 0;
    n_total++; if (pc !== 32'h100 || ifid_valid !== 1'b0)
      $display("FAIL j_redirect: got pc %h valid %b exp %h 0", pc, ifid_valid, 32'h100); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin found = 1; break; end
      n_total++; if (imem_ready !== 1'b1) $display("FAIL discard_ready: got %b exp 1", imem_ready); else n_pass++;
      n++;
      @(negedge clk);
    end
    n_total++; if (!found || n != 3) $display("FAIL discard_cycles: got %0d exp 3", n); else n_pass++;
  endtask

  task automatic test_wrap_async_reset;
    exp_req_q.push_back(32'h104); exp_ifid_q.push_back(32'h104);
    wait_issue(32'h104);
    mem_lat = 1;
    stall = 1;
    @(negedge clk);
    stall = 0; jump_id = 1; jump_target = 32'hFFFF_FFFC;
    exp_req_q.push_back(32'hFFFF_FFFC); exp_ifid_q.push_back(32'h0);
    exp_req_q.push_back(32'h0);
    @(negedge clk);
    jump_id = 0;
    n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h exp %h", pc, 32'hFFFF_FFFC); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1)
      $display("FAIL wrap_pc: got pc %h pc4 %h valid %b exp 0 0 1", pc, ifid_pc4, ifid_valid); else n_pass++;
    exp_req_q.push_back(32'h4); exp_ifid_q.push_back(32'h4);
    wait_issue(32'h4);
    mem_lat = 3;
    @(negedge clk);
    n_total++; if (imem_ready !== 1'b1 || pc !== 32'h4)
      $display("FAIL pre_rst_wait: got ready %b pc %h exp 1 %h", imem_ready, pc, 32'h4); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (pc !== 32'h0) $display("FAIL async_rst_pc: got %h exp %h", pc, 32'h0); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0)
      $display("FAIL async_rst_ifid: got valid %b pc4 %h instr %h exp 0 0 0", ifid_valid, ifid_pc4, ifid_instr); else n_pass++;
    n_total++; if (imem_req !== 1'b0 || imem_ready !== 1'b0)
      $display("FAIL async_rst_mem: got req %b ready %b exp 0 0", imem_req, imem_ready); else n_pass++;
  endtask

  task automatic test_release;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_req_q.push_back(32'h0);
    @(negedge clk);
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL release_req: got req %b addr %h exp 1 0", imem_req, imem_addr); else n_pass++;
    #2;
    n_total++; if (exp_req_q.size() != 0 || exp_ifid_q.size() != 0)
      $display("FAIL sb_drain: got req %0d ifid %0d left exp 0 0", exp_req_q.size(), exp_ifid_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch_same_cycle();
    test_stall_branch();
    test_not_taken();
    test_redirect_outstanding();
    test_wrap_async_reset();
    test_release();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
